// File: rtl/regfile_read_arbiter_pkg.sv
// rtl/regfile_read_arbiter_pkg.sv - shared core constants and types for the regfile read arbiter
package regfile_read_arbiter_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int REG_W     = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_read_arbiter_rr_pick.sv
// rtl/regfile_read_arbiter_rr_pick.sv - one-hot round-robin picker, first request at or after ptr
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] win_o,
    output logic          any_o
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        win_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                win_o      = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares the two regfile read ports among NREQ requesters
// with a commit snoop on the captured operands and a flush blackout after clear.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int ROB_W     = ROB_WIDTH,
    parameter int FLUSH_CYC = 1,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*REG_W-1:0] req_rs1,
    input  logic [NREQ*REG_W-1:0] req_rs2,
    output logic [NREQ-1:0]       gnt,
    output reg_idx_t              get_reg_1,
    output reg_idx_t              get_reg_2,
    input  logic [31:0]           get_val_1,
    input  logic [31:0]           get_val_2,
    input  logic                  has_dep_1,
    input  logic                  has_dep_2,
    input  logic [ROB_W-1:0]      get_dep_1,
    input  logic [ROB_W-1:0]      get_dep_2,
    input  reg_idx_t              commit_reg_id,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [31:0]           commit_val,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [31:0]           resp_val1,
    output logic [31:0]           resp_val2,
    output logic                  resp_has_dep1,
    output logic                  resp_has_dep2,
    output logic [ROB_W-1:0]      resp_dep1,
    output logic [ROB_W-1:0]      resp_dep2
);

    localparam int CNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_en;
    logic [NREQ-1:0]  pick_req;
    logic [IDW-1:0]   win;
    logic             grant;
    reg_idx_t         rs1_sel, rs2_sel;

    logic             resp_valid_q;
    logic [IDW-1:0]   resp_id_q;
    logic [31:0]      val1_q, val2_q, cap_val1, cap_val2;
    logic             hd1_q, hd2_q, cap_hd1, cap_hd2;
    logic [ROB_W-1:0] dep1_q, dep2_q, cap_dep1, cap_dep2;

    // A commit landing in the grant cycle resolves the dependency the regfile still reports.
    function automatic logic [ROB_W+32:0] snoop(
        input reg_idx_t         rs,
        input logic [31:0]      val,
        input logic             hd,
        input logic [ROB_W-1:0] dep,
        input reg_idx_t         c_reg,
        input logic [ROB_W-1:0] c_rob,
        input logic [31:0]      c_val
    );
        if (rs == '0)
            return '0;
        if (hd && (c_reg != '0) && (c_rob == dep))
            return {c_val, 1'b0, dep};
        return {val, hd, dep};
    endfunction

    rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .req_i (pick_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .win_o (win),
        .any_o (grant)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_FLUSH;
            ptr_d   = '0;
            cnt_d   = CNT_W'(FLUSH_CYC);
        end else if (rdy_in) begin
            case (state_q)
                ST_RUN: begin
                    if (grant)
                        ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                end
                ST_FLUSH: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        grant_en = rdy_in && !clear && (state_q == ST_RUN);
        pick_req = grant_en ? req : '0;
    end

    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                rs1_sel = req_rs1[i*REG_W +: REG_W];
                rs2_sel = req_rs2[i*REG_W +: REG_W];
            end
        end
    end

    assign get_reg_1 = rs1_sel;
    assign get_reg_2 = rs2_sel;

    always_comb begin
        {cap_val1, cap_hd1, cap_dep1} = snoop(rs1_sel, get_val_1, has_dep_1, get_dep_1,
                                              commit_reg_id, commit_rob_id, commit_val);
        {cap_val2, cap_hd2, cap_dep2} = snoop(rs2_sel, get_val_2, has_dep_2, get_dep_2,
                                              commit_reg_id, commit_rob_id, commit_val);
    end

    // Data fields only move on a grant; clear and stalls leave them as last captured.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            val1_q       <= '0;
            val2_q       <= '0;
            hd1_q        <= 1'b0;
            hd2_q        <= 1'b0;
            dep1_q       <= '0;
            dep2_q       <= '0;
        end else if (clear) begin
            resp_valid_q <= 1'b0;
        end else if (rdy_in) begin
            resp_valid_q <= grant;
            if (grant) begin
                resp_id_q <= win;
                val1_q    <= cap_val1;
                val2_q    <= cap_val2;
                hd1_q     <= cap_hd1;
                hd2_q     <= cap_hd2;
                dep1_q    <= cap_dep1;
                dep2_q    <= cap_dep2;
            end
        end
    end

    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_val1     = val1_q;
    assign resp_val2     = val2_q;
    assign resp_has_dep1 = hd1_q;
    assign resp_has_dep2 = hd2_q;
    assign resp_dep1     = dep1_q;
    assign resp_dep2     = dep2_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - randomized and directed bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    localparam int N  = 3;
    localparam int RW = 4;
    localparam int FC = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          clear  = 1'b0;
    logic [N-1:0]  req    = '0;
    logic [N*5-1:0] req_rs1 = '0;
    logic [N*5-1:0] req_rs2 = '0;
    logic [N-1:0]  gnt;
    logic [4:0]    get_reg_1, get_reg_2;
    logic [31:0]   get_val_1 = '0, get_val_2 = '0;
    logic          has_dep_1 = 1'b0, has_dep_2 = 1'b0;
    logic [RW-1:0] get_dep_1 = '0, get_dep_2 = '0;
    logic [4:0]    commit_reg_id = '0;
    logic [RW-1:0] commit_rob_id = '0;
    logic [31:0]   commit_val = '0;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [31:0]   resp_val1, resp_val2;
    logic          resp_has_dep1, resp_has_dep2;
    logic [RW-1:0] resp_dep1, resp_dep2;

    int n_checks = 0;
    int n_pass   = 0;

    int            m_ptr, m_cnt, e_id;
    bit            m_fl, e_rv;
    logic [31:0]   e_v1, e_v2;
    logic          e_h1, e_h2;
    logic [RW-1:0] e_d1, e_d2;
    logic [N-1:0]  m_gnt, obs_gnt;
    logic [2:0]    rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    regfile_read_arbiter #(.NREQ(N), .ROB_W(RW), .FLUSH_CYC(FC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .req(req), .req_rs1(req_rs1), .req_rs2(req_rs2), .gnt(gnt),
        .get_reg_1(get_reg_1), .get_reg_2(get_reg_2),
        .get_val_1(get_val_1), .get_val_2(get_val_2),
        .has_dep_1(has_dep_1), .has_dep_2(has_dep_2),
        .get_dep_1(get_dep_1), .get_dep_2(get_dep_2),
        .commit_reg_id(commit_reg_id), .commit_rob_id(commit_rob_id), .commit_val(commit_val),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_val1(resp_val1), .resp_val2(resp_val2),
        .resp_has_dep1(resp_has_dep1), .resp_has_dep2(resp_has_dep2),
        .resp_dep1(resp_dep1), .resp_dep2(resp_dep2)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_fl = 0;
        e_rv = 0; e_id = 0;
        e_v1 = '0; e_v2 = '0; e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
    endtask

    task automatic capture(input logic [4:0] rs, input logic [31:0] v, input logic h,
                           input logic [RW-1:0] d, output logic [31:0] ov,
                           output logic oh, output logic [RW-1:0] od);
        if (rs == 0) begin
            ov = '0; oh = 1'b0; od = '0;
        end else if (h && commit_reg_id != 0 && commit_rob_id == d) begin
            ov = commit_val; oh = 1'b0; od = d;
        end else begin
            ov = v; oh = h; od = d;
        end
    endtask

    // Inputs are set by the caller at posedge+1; everything is sampled at posedge+2.
    task automatic step();
        int w;
        logic [4:0] r1, r2;
        #1;
        w = -1;
        m_gnt = '0;
        r1 = '0;
        r2 = '0;
        if (rdy_in && !clear && !m_fl)
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
            m_gnt[w] = 1'b1;
            r1 = req_rs1[w*5 +: 5];
            r2 = req_rs2[w*5 +: 5];
        end
        obs_gnt = gnt;
        check("gnt", gnt, m_gnt);
        check("get_reg_1", get_reg_1, r1);
        check("get_reg_2", get_reg_2, r2);
        check("resp_valid", resp_valid, e_rv);
        check("resp_id", resp_id, e_id);
        check("resp_val1", resp_val1, e_v1);
        check("resp_val2", resp_val2, e_v2);
        check("resp_has_dep1", resp_has_dep1, e_h1);
        check("resp_has_dep2", resp_has_dep2, e_h2);
        if (e_h1) check("resp_dep1", resp_dep1, e_d1);
        if (e_h2) check("resp_dep2", resp_dep2, e_d2);
        if (clear) begin
            m_fl = 1; m_cnt = FC; m_ptr = 0; e_rv = 0;
        end else if (rdy_in) begin
            if (m_fl) begin
                m_cnt--;
                if (m_cnt <= 0) m_fl = 0;
            end
            e_rv = (w >= 0);
            if (w >= 0) begin
                e_id = w;
                capture(r1, get_val_1, has_dep_1, get_dep_1, e_v1, e_h1, e_d1);
                capture(r2, get_val_2, has_dep_2, get_dep_2, e_v2, e_h2, e_d2);
                m_ptr = (w + 1) % N;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk_in);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_get_reg_1", get_reg_1, 0);
        check("rst_get_reg_2", get_reg_2, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_val1", resp_val1, 0);
        check("rst_resp_val2", resp_val2, 0);
        check("rst_resp_hd", {resp_has_dep1, resp_has_dep2}, 0);
        check("rst_resp_dep", {resp_dep1, resp_dep2}, 0);
        rst_in = 1'b1;
        repeat (5) step();

        req_rs1 = {5'd3, 5'd2, 5'd1};
        req_rs2 = {5'd13, 5'd12, 5'd11};
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rr_order", obs_gnt, rr_exp[k]);
            check("rr_resp_id", resp_id, k % N);
        end

        req = 3'b001;
        req_rs1[4:0] = 5'd5;
        get_val_1 = 32'h5555; has_dep_1 = 1'b1; get_dep_1 = 4'd3;
        commit_reg_id = 5'd5; commit_rob_id = 4'd3; commit_val = 32'hDEAD_BEEF;
        step();
        check("snoop_val1", resp_val1, 32'hDEAD_BEEF);
        check("snoop_has_dep1", resp_has_dep1, 0);
        commit_rob_id = 4'd4;
        step();
        check("nosnoop_has_dep1", resp_has_dep1, 1);
        check("nosnoop_dep1", resp_dep1, 3);

        req_rs1[4:0] = 5'd0;
        get_val_1 = 32'h1234; has_dep_1 = 1'b1; commit_reg_id = 5'd0;
        step();
        check("x0_val1", resp_val1, 0);
        check("x0_has_dep1", resp_has_dep1, 0);

        req_rs1 = {5'd3, 5'd2, 5'd1};
        req = 3'b111;
        clear = 1'b1;
        step();
        check("clr_gnt", obs_gnt, 0);
        clear = 1'b0;
        check("clr_no_resp", resp_valid, 0);
        step();
        check("flush_gnt_a", obs_gnt, 0);
        step();
        check("flush_gnt_b", obs_gnt, 0);
        step();
        check("post_flush_gnt", obs_gnt, 3'b001);

        rdy_in = 1'b0;
        repeat (3) begin
            step();
            check("stall_gnt", obs_gnt, 0);
        end
        rdy_in = 1'b1;
        step();
        check("resume_gnt", obs_gnt, 3'b010);
        check("resume_resp_valid", resp_valid, 1);
        #1 rst_in = 1'b0;
        #1;
        check("arst_resp_valid", resp_valid, 0);
        check("arst_resp_id", resp_id, 0);
        model_reset();
        rst_in = 1'b1;

        req = '0;
        for (int c = 0; c < 2000; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    req_rs1[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_rs2[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                end
            end
            get_val_1 = $urandom; get_val_2 = $urandom;
            has_dep_1 = 1'($urandom_range(0, 1)); has_dep_2 = 1'($urandom_range(0, 1));
            get_dep_1 = RW'($urandom_range(0, 15)); get_dep_2 = RW'($urandom_range(0, 15));
            commit_reg_id = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            case ($urandom_range(0, 2))
                0:       commit_rob_id = get_dep_1;
                1:       commit_rob_id = get_dep_2;
                default: commit_rob_id = RW'($urandom_range(0, 15));
            endcase
            commit_val = $urandom;
            step();
            for (int i = 0; i < N; i++)
                if (m_gnt[i]) req[i] = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
